// File: rtl/rvfpm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rvfpm_pkg
//  Description : Shared types and width helpers for the rvfpm issue front-end.
//  Revision    : 1.0  initial release
// ============================================================================
package rvfpm_pkg;

    localparam int C_X_ID_WIDTH  = 4;
    localparam int C_INSTR_WIDTH = 32;

    // Reference layouts at the default widths; parameterised blocks keep the
    // same {valid, id, instr} ordering with their own field widths.
    typedef struct packed {
        logic                     valid;
        logic [C_X_ID_WIDTH-1:0]  id;
        logic [C_INSTR_WIDTH-1:0] instr;
    } rvfpm_q_entry_t;

    typedef struct packed {
        logic                    valid;
        logic [C_X_ID_WIDTH-1:0] id;
    } rvfpm_pipe_entry_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvfpm_id_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rvfpm_id_pipe
//  Description : {valid, id} shift register shadowing the FPU pipeline, with
//                stall hold, kill-by-ID clear and completion report.
//  Revision    : 1.0  initial release
// ============================================================================
module rvfpm_id_pipe
    import rvfpm_pkg::*;
#(
    parameter int X_ID_WIDTH      = 4,
    parameter int PIPELINE_STAGES = 4
) (
    input  logic                                       ck,
    input  logic                                       rst,
    input  logic                                       stall,
    input  logic                                       in_valid,
    input  logic [X_ID_WIDTH-1:0]                      in_id,
    input  logic                                       kill_valid,
    input  logic [X_ID_WIDTH-1:0]                      kill_id,
    output logic                                       done_valid,
    output logic [X_ID_WIDTH-1:0]                      done_id,
    output logic [PIPELINE_STAGES-1:0][X_ID_WIDTH-1:0] pipeline_ids
);

    localparam int C_LAST = PIPELINE_STAGES - 1;

    logic [PIPELINE_STAGES-1:0]                 r_valid;
    logic [PIPELINE_STAGES-1:0][X_ID_WIDTH-1:0] r_id;
    logic [PIPELINE_STAGES-1:0]                 w_hit;
    logic [PIPELINE_STAGES-1:0]                 w_src_valid;
    logic [PIPELINE_STAGES-1:0][X_ID_WIDTH-1:0] w_src_id;

    for (genvar s = 0; s < PIPELINE_STAGES; s++) begin : g_stage
        assign w_hit[s] = kill_valid & (r_id[s] == kill_id);
        if (s == 0) begin : g_first
            assign w_src_valid[s] = in_valid;
            assign w_src_id[s]    = in_id;
        end else begin : g_rest
            // A killed entry keeps travelling as a bubble carrying its ID.
            assign w_src_valid[s] = r_valid[s-1] & ~w_hit[s-1];
            assign w_src_id[s]    = r_id[s-1];
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            r_valid <= '0;
            r_id    <= '0;
        end else if (!stall) begin
            r_valid <= w_src_valid;
            r_id    <= w_src_id;
        end else begin
            r_valid <= r_valid & ~w_hit;
        end
    end

    assign done_valid   = r_valid[C_LAST] & ~stall & ~w_hit[C_LAST];
    assign done_id      = r_id[C_LAST];
    assign pipeline_ids = r_id;

endmodule
`default_nettype wire

// File: rtl/rvfpm_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : rvfpm_issue_queue
//  Description : Offloaded-instruction FIFO feeding the rvfpm FPU datapath with
//                per-stage ID tracking. Define RVFPM_KILL_EN for kill-by-ID.
//  Revision    : 1.0  initial release
// ============================================================================
module rvfpm_issue_queue
    import rvfpm_pkg::*;
#(
    parameter int X_ID_WIDTH      = 4,
    parameter int QUEUE_DEPTH     = 4,
    parameter int PIPELINE_STAGES = 4,
    parameter int INSTR_WIDTH     = 32
) (
    input  logic                                       ck,
    input  logic                                       rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [INSTR_WIDTH-1:0]                     in_instr,
    input  logic [X_ID_WIDTH-1:0]                      in_id,
    input  logic                                       pipe_stall,
    output logic                                       issue_valid,
    output logic [INSTR_WIDTH-1:0]                     issue_instr,
    output logic [X_ID_WIDTH-1:0]                      issue_id,
    output logic                                       done_valid,
    output logic [X_ID_WIDTH-1:0]                      done_id,
`ifdef RVFPM_KILL_EN
    input  logic                                       kill_valid,
    input  logic [X_ID_WIDTH-1:0]                      kill_id,
`endif
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]           queue_count,
    output logic [QUEUE_DEPTH-1:0][X_ID_WIDTH-1:0]     queue_ids,
    output logic [PIPELINE_STAGES-1:0][X_ID_WIDTH-1:0] pipeline_ids
);

    localparam int                 C_PTR_W    = ptr_width(QUEUE_DEPTH);
    localparam int                 C_CNT_W    = count_width(QUEUE_DEPTH);
    localparam logic [C_PTR_W-1:0] C_PTR_LAST = C_PTR_W'(QUEUE_DEPTH - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_FULL = C_CNT_W'(QUEUE_DEPTH);

    logic [QUEUE_DEPTH-1:0]                  r_valid;
    logic [QUEUE_DEPTH-1:0][X_ID_WIDTH-1:0]  r_id;
    logic [QUEUE_DEPTH-1:0][INSTR_WIDTH-1:0] r_instr;
    logic [C_PTR_W-1:0]                      r_head;
    logic [C_PTR_W-1:0]                      r_tail;
    logic [C_CNT_W-1:0]                      r_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_nonempty;
    logic                  w_kill_valid;
    logic [X_ID_WIDTH-1:0] w_kill_id;
    logic                  w_s0_valid;
    logic [X_ID_WIDTH-1:0] w_s0_id;

    function automatic logic [C_PTR_W-1:0] f_next(input logic [C_PTR_W-1:0] p);
        return (p == C_PTR_LAST) ? '0 : p + C_PTR_W'(1);
    endfunction

`ifdef RVFPM_KILL_EN
    assign w_kill_valid = kill_valid;
    assign w_kill_id    = kill_id;
`else
    assign w_kill_valid = 1'b0;
    assign w_kill_id    = '0;
`endif

    assign w_nonempty = (r_count != '0);
    assign w_issue    = w_nonempty & r_valid[r_head] & ~pipe_stall;
`ifdef RVFPM_KILL_EN
    // A killed head is discarded even while the pipeline is frozen.
    assign w_pop      = w_issue | (w_nonempty & ~r_valid[r_head]);
`else
    assign w_pop      = w_issue;
`endif
    assign in_ready   = ~rst & (r_count < C_CNT_FULL);
    assign w_push     = in_valid & in_ready;

    always_ff @(posedge ck) begin
        if (rst) begin
            r_valid <= '0;
            r_id    <= '0;
            r_instr <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (w_kill_valid && (r_id[i] == w_kill_id)) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= f_next(r_head);
            end
            // Placed after the kill loop so a same-cycle push survives a kill.
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_id[r_tail]    <= in_id;
                r_instr[r_tail] <= in_instr;
                r_tail          <= f_next(r_tail);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign issue_valid = w_issue;
    assign issue_instr = r_instr[r_head];
    assign issue_id    = r_id[r_head];
    assign queue_count = r_count;
    assign queue_ids   = r_id;

    assign w_s0_valid  = w_issue & ~(w_kill_valid & (r_id[r_head] == w_kill_id));
    assign w_s0_id     = w_issue ? r_id[r_head] : '0;

    rvfpm_id_pipe #(
        .X_ID_WIDTH      (X_ID_WIDTH),
        .PIPELINE_STAGES (PIPELINE_STAGES)
    ) u_id_pipe (
        .ck           (ck),
        .rst          (rst),
        .stall        (pipe_stall),
        .in_valid     (w_s0_valid),
        .in_id        (w_s0_id),
        .kill_valid   (w_kill_valid),
        .kill_id      (w_kill_id),
        .done_valid   (done_valid),
        .done_id      (done_id),
        .pipeline_ids (pipeline_ids)
    );

endmodule
`default_nettype wire

// File: tb/tb_rvfpm_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rvfpm_issue_queue
//  Description : Directed scoreboard bench for rvfpm_issue_queue (default
//                depth 4 instance plus a depth-3 wrap-around instance).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rvfpm_issue_queue;

    logic ck  = 1'b0;
    logic rst = 1'b1;
    always #5 ck = ~ck;

    // Default-configuration instance
    logic             in_valid, in_ready, pipe_stall, issue_valid, done_valid;
    logic [31:0]      in_instr, issue_instr;
    logic [3:0]       in_id, issue_id, done_id;
    logic [2:0]       queue_count;
    logic [3:0][3:0]  queue_ids;
    logic [3:0][3:0]  pipeline_ids;
`ifdef RVFPM_KILL_EN
    logic             kill_valid;
    logic [3:0]       kill_id;
`endif

    // QUEUE_DEPTH = 3 instance
    logic             b_in_valid, b_in_ready, b_stall, b_issue_valid, b_done_valid;
    logic [31:0]      b_in_instr, b_issue_instr;
    logic [3:0]       b_in_id, b_issue_id, b_done_id;
    logic [1:0]       b_queue_count;
    logic [2:0][3:0]  b_queue_ids;
    logic [3:0][3:0]  b_pipeline_ids;

    rvfpm_issue_queue dut (
        .ck           (ck),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_id        (in_id),
        .pipe_stall   (pipe_stall),
        .issue_valid  (issue_valid),
        .issue_instr  (issue_instr),
        .issue_id     (issue_id),
        .done_valid   (done_valid),
        .done_id      (done_id),
`ifdef RVFPM_KILL_EN
        .kill_valid   (kill_valid),
        .kill_id      (kill_id),
`endif
        .queue_count  (queue_count),
        .queue_ids    (queue_ids),
        .pipeline_ids (pipeline_ids)
    );

    rvfpm_issue_queue #(.QUEUE_DEPTH(3)) dut_b (
        .ck           (ck),
        .rst          (rst),
        .in_valid     (b_in_valid),
        .in_ready     (b_in_ready),
        .in_instr     (b_in_instr),
        .in_id        (b_in_id),
        .pipe_stall   (b_stall),
        .issue_valid  (b_issue_valid),
        .issue_instr  (b_issue_instr),
        .issue_id     (b_issue_id),
        .done_valid   (b_done_valid),
        .done_id      (b_done_id),
`ifdef RVFPM_KILL_EN
        .kill_valid   (1'b0),
        .kill_id      (4'd0),
`endif
        .queue_count  (b_queue_count),
        .queue_ids    (b_queue_ids),
        .pipeline_ids (b_pipeline_ids)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         got_b    = 0;
    logic [3:0] sb_a[$];
    logic [3:0] sb_b[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge ck);
    endtask

    // Completion monitors: every done must match the oldest expected ID.
    always @(negedge ck) begin
        #2;
        if (!rst && done_valid) begin
            if (sb_a.size() == 0) chk("a_done_spurious", 64'(done_valid), 64'd0);
            else                  chk("a_done_order", 64'(done_id), 64'(sb_a.pop_front()));
        end
    end

    always @(negedge ck) begin
        #2;
        if (!rst && b_done_valid) begin
            got_b++;
            if (sb_b.size() == 0) chk("b_done_spurious", 64'(b_done_valid), 64'd0);
            else                  chk("b_done_order", 64'(b_done_id), 64'(sb_b.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][3:0] exp_p;
        logic [3:0][3:0] exp_q;
        int              sent;

        in_valid = 0; in_instr = 0; in_id = 0; pipe_stall = 0;
        b_in_valid = 0; b_in_instr = 0; b_in_id = 0; b_stall = 0;
`ifdef RVFPM_KILL_EN
        kill_valid = 0; kill_id = 0;
`endif
        // Reset state
        repeat (2) step();
        #1;
        chk("rst_in_ready",     64'(in_ready), 64'd0);
        chk("rst_issue_valid",  64'(issue_valid), 64'd0);
        chk("rst_issue_id",     64'(issue_id), 64'd0);
        chk("rst_done",         64'({done_valid, done_id}), 64'd0);
        chk("rst_count",        64'(queue_count), 64'd0);
        chk("rst_queue_ids",    64'(queue_ids), 64'd0);
        chk("rst_pipe_ids",     64'(pipeline_ids), 64'd0);
        step();
        rst = 0;
        #1 chk("post_rst_ready", 64'(in_ready), 64'd1);

        // Single instruction latency: push N, issue N+1, done N+5
        in_valid = 1; in_id = 4'd3; in_instr = 32'h00A5_0053; sb_a.push_back(4'd3);
        step();
        in_valid = 0;
        #1;
        chk("single_issue_valid", 64'(issue_valid), 64'd1);
        chk("single_issue_id",    64'(issue_id), 64'd3);
        chk("single_issue_instr", 64'(issue_instr), 64'h00A5_0053);
        repeat (3) step();
        #1 chk("single_not_early", 64'(done_valid), 64'd0);
        step();
        #1;
        chk("single_done_valid", 64'(done_valid), 64'd1);
        chk("single_done_id",    64'(done_id), 64'd3);

        // Fill under stall, no bypass when full
        step();
        pipe_stall = 1;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1; in_id = 4'(k); in_instr = 32'(k);
            #1 chk("fill_ready", 64'(in_ready), (k <= 4) ? 64'd1 : 64'd0);
            if (k <= 4) begin
                sb_a.push_back(4'(k));
                step();
            end
        end
        chk("fill_count", 64'(queue_count), 64'd4);
        exp_q[0] = 4'd4; exp_q[1] = 4'd1; exp_q[2] = 4'd2; exp_q[3] = 4'd3;
        chk("fill_queue_ids", 64'(queue_ids), 64'(exp_q));
        pipe_stall = 0;
        #1;
        chk("full_no_bypass", 64'(in_ready), 64'd0);
        chk("fill_issue_id",  64'(issue_id), 64'd1);
        sb_a.push_back(4'd5);
        step();
        #1;
        chk("fill_slot_freed", 64'(in_ready), 64'd1);
        chk("fill_issue2_id",  64'(issue_id), 64'd2);
        step();
        in_valid = 0;
        repeat (12) step();
        #1;
        chk("fill_drained_count", 64'(queue_count), 64'd0);
        chk("fill_drained_sb",    64'(sb_a.size()), 64'd0);

        // Stall while id 7 sits in stage 2
        in_valid = 1; in_id = 4'd7; in_instr = 32'h7; sb_a.push_back(4'd7);
        step();
        in_valid = 0;
        repeat (3) step();
        pipe_stall = 1;
        exp_p = '0; exp_p[2] = 4'd7;
        #1 chk("stall_pipe_ids", 64'(pipeline_ids), 64'(exp_p));
        repeat (2) begin
            step();
            #1 chk("stall_pipe_hold", 64'(pipeline_ids), 64'(exp_p));
        end
        step();
        pipe_stall = 0;
        #1 chk("stall_not_early", 64'(done_valid), 64'd0);
        step();
        #1;
        chk("stall_done_valid", 64'(done_valid), 64'd1);
        chk("stall_done_id",    64'(done_id), 64'd7);

        // Depth-3 instance: fill check, then random-stall stream through wrap
        b_stall = 1;
        for (int k = 12; k <= 14; k++) begin
            b_in_valid = 1; b_in_id = 4'(k); b_in_instr = 32'(k);
            sb_b.push_back(4'(k));
            step();
        end
        b_in_valid = 0;
        #1;
        chk("b_full_ready", 64'(b_in_ready), 64'd0);
        chk("b_full_count", 64'(b_queue_count), 64'd3);
        sent = 0;
        for (int cyc = 0; cyc < 300 && got_b < 13; cyc++) begin
            b_stall    = ($urandom_range(0, 2) == 0);
            b_in_valid = (sent < 10);
            b_in_id    = 4'(sent);
            b_in_instr = 32'(sent);
            #1;
            if (b_in_valid && b_in_ready) begin
                sb_b.push_back(4'(sent));
                sent++;
            end
            step();
        end
        b_in_valid = 0; b_stall = 0;
        chk("b_all_done",  64'(got_b), 64'd13);
        chk("b_sb_empty",  64'(sb_b.size()), 64'd0);
        chk("b_count_end", 64'(b_queue_count), 64'd0);

`ifdef RVFPM_KILL_EN
        // Kill a queued ID: only 2 and 6 issue
        step();
        pipe_stall = 1;
        for (int k = 2; k <= 6; k += 2) begin
            in_valid = 1; in_id = 4'(k); in_instr = 32'(k);
            if (k != 4) sb_a.push_back(4'(k));
            step();
        end
        in_valid = 0; kill_valid = 1; kill_id = 4'd4;
        step();
        kill_valid = 0;
        #1 chk("kill_count_held", 64'(queue_count), 64'd3);
        pipe_stall = 0;
        #1 chk("kill_issue_2", 64'({issue_valid, issue_id}), 64'h12);
        step();
        #1 chk("kill_silent_pop", 64'(issue_valid), 64'd0);
        step();
        #1 chk("kill_issue_6", 64'({issue_valid, issue_id}), 64'h16);
        // Kill the entry while it sits in the last stage
        repeat (6) step();
        in_valid = 1; in_id = 4'd9; in_instr = 32'h9;
        step();
        in_valid = 0;
        repeat (4) step();
        kill_valid = 1; kill_id = 4'd9;
        #1 chk("kill_last_stage_masked", 64'(done_valid), 64'd0);
        step();
        kill_valid = 0;
        repeat (4) step();
`endif

        // Reset mid-stream with 3 queued and 2 in flight
        for (int k = 11; k <= 12; k++) begin
            in_valid = 1; in_id = 4'(k); in_instr = 32'(k);
            sb_a.push_back(4'(k));
            step();
        end
        in_valid = 0;
        step();
        pipe_stall = 1;
        for (int k = 13; k <= 15; k++) begin
            in_valid = 1; in_id = 4'(k); in_instr = 32'(k);
            sb_a.push_back(4'(k));
            step();
        end
        in_valid = 0;
        #1 chk("pre_rst_count", 64'(queue_count), 64'd3);
        rst = 1;
        sb_a.delete();
        #1 chk("mid_rst_ready", 64'(in_ready), 64'd0);
        step();
        rst = 0;
        pipe_stall = 0;
        #1;
        chk("after_rst_count",    64'(queue_count), 64'd0);
        chk("after_rst_issue",    64'({issue_valid, issue_id}), 64'd0);
        chk("after_rst_done",     64'({done_valid, done_id}), 64'd0);
        chk("after_rst_qids",     64'(queue_ids), 64'd0);
        chk("after_rst_pids",     64'(pipeline_ids), 64'd0);
        chk("after_rst_ready",    64'(in_ready), 64'd1);
        repeat (10) step();
        #3;
        chk("final_sb_empty", 64'(sb_a.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
